div_ctrl: RTL

Multi-cycle divide sequencer for the EX stage. Accepts a DIV/DIVU request, latches operands, runs a 32-iteration restoring shift-subtract divide, and holds the 64-bit result until the instruction leaves EX. While the divide is in progress it raises the EX stall request toward the pipeline stall controller.

---
 rtl/div_ctrl_pkg.sv | 24 ++
 rtl/div_iter.sv | 33 +++
 rtl/div_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: FSM state encodings,
// start/ready handshake constants reused by EX, and the latched sign context.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ZERO = 2'b01,
      ST_CALC = 2'b10,
      ST_DONE = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // Sign context captured when a request is accepted.
   typedef struct packed {
      logic signed_div;  // 1 = DIV, 0 = DIVU
      logic neg_q;       // quotient must be negated at the end
      logic neg_r;       // remainder must be negated at the end
   } div_sign_t;

endpackage

// File: rtl/div_iter.sv
// One restoring shift-subtract divide step. The partial remainder is widened
// by one bit before the trial subtract, so large divisors never overflow.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] quotient_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] p_o,
   output logic [WIDTH-1:0] dividend_o,
   output logic [WIDTH-1:0] quotient_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // Shift in the next dividend bit, trial-subtract, restore on borrow.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later lines see the
      // values computed above them within the same evaluation.
      shifted    = {p_i, dividend_i[WIDTH-1]};
      diff       = shifted - {1'b0, divisor_i};
      // p < divisor holds on entry, so a non-negative difference is below
      // 2^WIDTH and its top bit acts as the borrow flag.
      fits       = ~diff[WIDTH];
      p_o        = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dividend_o = {dividend_i[WIDTH-2:0], 1'b0};
      quotient_o = {quotient_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage. Latches operand magnitudes
// and signs on acceptance, runs WIDTH restoring iterations, applies the sign
// fix-up and holds {remainder, quotient} until the instruction leaves EX.
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               busy,
   output logic               stallreq
);

   import div_ctrl_pkg::*;

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   p_q, p_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   div_sign_t          sign_q, sign_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   p_nxt, dvd_nxt, quo_nxt;
   logic               sign1, sign2;
   logic               div_by_zero;
   logic               last_iter;

   assign sign1       = signed_div & opdata1[WIDTH-1];
   assign sign2       = signed_div & opdata2[WIDTH-1];
   assign div_by_zero = (opdata2 == '0);
   assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));

   // Negation is mod 2^WIDTH, which makes MIN / -1 come out as MIN rem 0.
   function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                   input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   div_iter #(
      .WIDTH (WIDTH)
   ) u_div_iter (
      .p_i        (p_q),
      .dividend_i (dvd_q),
      .quotient_i (quo_q),
      .divisor_i  (dvs_q),
      .p_o        (p_nxt),
      .dividend_o (dvd_nxt),
      .quotient_o (quo_nxt)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // pre-edge values regardless of block ordering.
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; annul overrides everything, including a held start.
   always_comb begin
      state_d = state_q;
      if (annul) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start == DivStart) state_d = div_by_zero ? ST_ZERO : ST_CALC;
            ST_ZERO: state_d = ST_DONE;
            ST_CALC: if (last_iter) state_d = ST_DONE;
            ST_DONE: if (start == DivStop) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from the state; the stall request is purely combinational.
   always_comb begin
      ready    = (state_q == ST_DONE) ? DivResultReady : DivResultNotReady;
      busy     = (state_q != ST_IDLE);
      stallreq = start & ~ready & ~annul;
      result   = result_q;
   end

   // Datapath next values: operand capture, iteration and result formation.
   always_comb begin
      // NOTE: every target gets a hold default first so no path infers a latch.
      cnt_d    = cnt_q;
      p_d      = p_q;
      dvd_d    = dvd_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      sign_d   = sign_q;
      result_d = result_q;
      if (!annul) begin
         case (state_q)
            ST_IDLE: begin
               if (start == DivStart) begin
                  sign_d = '{signed_div: signed_div,
                             neg_q:      sign1 ^ sign2,
                             neg_r:      sign1};
                  cnt_d  = '0;
                  p_d    = '0;
                  quo_d  = '0;
                  dvs_d  = apply_sign(sign2, opdata2);
                  // Divide by zero reports the dividend untouched, so keep
                  // the raw operand rather than its magnitude.
                  dvd_d  = div_by_zero ? opdata1 : apply_sign(sign1, opdata1);
               end
            end
            ST_ZERO: begin
               result_d = {dvd_q, {WIDTH{1'b1}}};
            end
            ST_CALC: begin
               p_d   = p_nxt;
               dvd_d = dvd_nxt;
               quo_d = quo_nxt;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  result_d = {apply_sign(sign_q.signed_div & sign_q.neg_r, p_nxt),
                              apply_sign(sign_q.signed_div & sign_q.neg_q, quo_nxt)};
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers; the result register is only written on the way into
   // DONE, which keeps it stable while EX is held.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: datapath registers are reset too, so the result bus reads zero
      // after reset instead of stale data.
      if (!resetn) begin
         cnt_q    <= '0;
         p_q      <= '0;
         dvd_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sign_q   <= '0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         dvd_q    <= dvd_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

endmodule
